// File: rtl/nmea_gga_parser.sv
// nmea_gga_parser: $GPGGA byte-stream parser with XOR checksum check and BCD field extraction
//   clk, rst          clock, asynchronous active-high reset
//   rx_data, rx_new   received byte and its one-cycle strobe
//   time_bcd          {8'h00, hh, mm, ss} BCD of the last good fix
//   lat_bcd, lon_bcd  latitude dd mm m1..m4 / longitude ddd mm m1..m3 BCD
//   lat_south, lon_west, fix_q   hemispheres and fix-quality digit
//   new_fix, sent_err one-cycle pulses: fix published / sentence rejected
//   busy              high while a sentence is being parsed
module nmea_gga_parser #(
    parameter int MAX_CHARS = 82
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    output logic [31:0] time_bcd,
    output logic [31:0] lat_bcd,
    output logic [31:0] lon_bcd,
    output logic        lat_south,
    output logic        lon_west,
    output logic [3:0]  fix_q,
    output logic        new_fix,
    output logic        sent_err,
    output logic        busy
);
    localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, FIELD = 3'd2, CS_HI = 3'd3, CS_LO = 3'd4, COMMIT = 3'd5;
    localparam logic [47:0] HDR_STR = "GPGGA,";

    logic [2:0]  state, hidx, fld, dcnt, fcnt;
    logic [7:0]  cs, cnt;
    logic [3:0]  rx_hi, sh_q;
    logic        frac, bad, sh_s, sh_w;
    logic [23:0] sh_time;
    logic [15:0] sh_lat_i, sh_lat_f;
    logic [19:0] sh_lon_i;
    logic [11:0] sh_lon_f;

    logic       is_dig, is_hex, cs_ok, end_bad, eol;
    logic [3:0] hex_val, lat_b, lon_b;
    logic [5:0] hdr_base;
    logic [7:0] hdr_ch;

    assign is_dig   = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_hex   = is_dig || (rx_data >= 8'h41 && rx_data <= 8'h46);
    assign hex_val  = is_dig ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    assign cs_ok    = cs == {rx_hi, hex_val};
    assign hdr_base = 6'd40 - {hidx, 3'b000};
    assign hdr_ch   = HDR_STR[hdr_base +: 8];
    // fraction digits fill left-justified from the most significant nibble
    assign lat_b    = 4'd12 - {fcnt[1:0], 2'b00};
    assign lon_b    = 4'd8 - {fcnt[1:0], 2'b00};
    assign eol      = rx_data == 8'h0D || rx_data == 8'h0A;
    // digit/char count check applied when a field closes
    assign end_bad  = (fld == 3'd1 && dcnt != 3'd6) || (fld == 3'd2 && dcnt != 3'd4) ||
                      (fld == 3'd4 && dcnt != 3'd5) || ((fld == 3'd3 || fld == 3'd5) && dcnt != 3'd1);
    assign busy     = state != IDLE && state != COMMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE; hidx <= '0; fld <= '0; dcnt <= '0; fcnt <= '0;
            cs <= '0; cnt <= '0; rx_hi <= '0; sh_q <= '0;
            frac <= 1'b0; bad <= 1'b0; sh_s <= 1'b0; sh_w <= 1'b0;
            sh_time <= '0; sh_lat_i <= '0; sh_lat_f <= '0; sh_lon_i <= '0; sh_lon_f <= '0;
            time_bcd <= '0; lat_bcd <= '0; lon_bcd <= '0;
            lat_south <= 1'b0; lon_west <= 1'b0; fix_q <= '0;
            new_fix <= 1'b0; sent_err <= 1'b0;
        end else begin
            new_fix  <= 1'b0;
            sent_err <= 1'b0;
            if (state == COMMIT) begin
                state <= IDLE;
            end else if (rx_new) begin
                if (rx_data == "$") begin
                    sent_err <= state != IDLE;
                    state <= HDR; cs <= '0; cnt <= 8'd1; hidx <= '0; fld <= '0;
                    dcnt <= '0; fcnt <= '0; frac <= 1'b0; bad <= 1'b0;
                    sh_time <= '0; sh_lat_i <= '0; sh_lat_f <= '0; sh_lon_i <= '0; sh_lon_f <= '0;
                    sh_s <= 1'b0; sh_w <= 1'b0; sh_q <= '0;
                end else if (state != IDLE && (cnt == 8'(MAX_CHARS) || (state != HDR && eol))) begin
                    sent_err <= 1'b1;
                    state <= IDLE;
                end else if (state != IDLE) begin
                    cnt <= cnt + 8'd1;
                    case (state)
                        HDR: begin
                            cs <= cs ^ rx_data;
                            if (rx_data != hdr_ch) state <= IDLE;
                            else if (hidx == 3'd5) begin state <= FIELD; fld <= 3'd1; end
                            else hidx <= hidx + 3'd1;
                        end
                        FIELD: begin
                            if (end_bad && (rx_data == "*" || rx_data == ",")) bad <= 1'b1;
                            if (rx_data == "*") state <= CS_HI;
                            else begin
                                cs <= cs ^ rx_data;
                                if (rx_data == ",") begin
                                    fld <= fld + {2'b0, fld != 3'd7};
                                    dcnt <= '0; fcnt <= '0; frac <= 1'b0;
                                end else if (fld == 3'd1 || fld == 3'd2 || fld == 3'd4) begin
                                    if (is_dig && !frac) begin
                                        dcnt <= dcnt + {2'b0, dcnt != 3'd7};
                                        if (fld == 3'd1) sh_time <= {sh_time[19:0], rx_data[3:0]};
                                        if (fld == 3'd2) sh_lat_i <= {sh_lat_i[11:0], rx_data[3:0]};
                                        if (fld == 3'd4) sh_lon_i <= {sh_lon_i[15:0], rx_data[3:0]};
                                    end else if (is_dig) begin
                                        fcnt <= fcnt + {2'b0, fcnt != 3'd7};
                                        if (fld == 3'd2 && fcnt < 3'd4) sh_lat_f[lat_b +: 4] <= rx_data[3:0];
                                        if (fld == 3'd4 && fcnt < 3'd3) sh_lon_f[lon_b +: 4] <= rx_data[3:0];
                                    end else if (rx_data == "." && !frac) frac <= 1'b1;
                                    else bad <= 1'b1;
                                end else if (fld == 3'd3 || fld == 3'd5) begin
                                    dcnt <= dcnt + {2'b0, dcnt != 3'd7};
                                    if (fld == 3'd3 && rx_data != "N" && rx_data != "S") bad <= 1'b1;
                                    if (fld == 3'd5 && rx_data != "E" && rx_data != "W") bad <= 1'b1;
                                    if (fld == 3'd3) sh_s <= rx_data == "S";
                                    if (fld == 3'd5) sh_w <= rx_data == "W";
                                end else if (fld == 3'd6) begin
                                    if (is_dig) sh_q <= rx_data[3:0];
                                    else bad <= 1'b1;
                                end
                            end
                        end
                        CS_HI: begin
                            rx_hi <= hex_val;
                            state <= is_hex ? CS_LO : IDLE;
                            sent_err <= !is_hex;
                        end
                        CS_LO: begin
                            state <= is_hex ? COMMIT : IDLE;
                            if (is_hex && cs_ok && !bad && sh_q != 4'd0) begin
                                new_fix <= 1'b1;
                                time_bcd <= {8'h00, sh_time};
                                lat_bcd <= {sh_lat_i, sh_lat_f};
                                lon_bcd <= {sh_lon_i, sh_lon_f};
                                lat_south <= sh_s; lon_west <= sh_w; fix_q <= sh_q;
                            end else begin
                                // a valid no-fix sentence (quality 0) is silently dropped
                                sent_err <= !(is_hex && cs_ok && sh_q == 4'd0);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_nmea_gga_parser.sv
// tb_nmea_gga_parser: scoreboard bench driving directed GGA sentences into nmea_gga_parser
`timescale 1ns/1ps
module tb_nmea_gga_parser;
    logic        clk, rst, rx_new;
    logic [7:0]  rx_data;
    logic [31:0] time_bcd, lat_bcd, lon_bcd;
    logic        lat_south, lon_west, new_fix, sent_err, busy;
    logic [3:0]  fix_q;

    nmea_gga_parser dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_new(rx_new),
        .time_bcd(time_bcd), .lat_bcd(lat_bcd), .lon_bcd(lon_bcd),
        .lat_south(lat_south), .lon_west(lon_west), .fix_q(fix_q),
        .new_fix(new_fix), .sent_err(sent_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          fix;
        int          byte_no;
        logic [31:0] t, la, lo;
        logic        s, w;
        logic [3:0]  q;
    } ev_t;

    ev_t sb[$];
    int tests = 0, fails = 0, bytes_sent = 0;
    logic [31:0] e_t, e_la, e_lo;
    logic        e_s, e_w;
    logic [3:0]  e_q;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(string tag);
        check({tag, " time_bcd"}, 64'(time_bcd), 64'(e_t));
        check({tag, " lat_bcd"}, 64'(lat_bcd), 64'(e_la));
        check({tag, " lon_bcd"}, 64'(lon_bcd), 64'(e_lo));
        check({tag, " lat_south"}, 64'(lat_south), 64'(e_s));
        check({tag, " lon_west"}, 64'(lon_west), 64'(e_w));
        check({tag, " fix_q"}, 64'(fix_q), 64'(e_q));
    endtask

    task automatic expect_ev(bit fix, int byte_no);
        sb.push_back('{fix, byte_no, e_t, e_la, e_lo, e_s, e_w, e_q});
    endtask

    task automatic send_byte(logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_new = 1'b1;
        bytes_sent++;
        @(negedge clk);
        rx_new = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (4) @(negedge clk);
    endtask

    always begin : mon
        ev_t ev;
        @(posedge clk);
        #1;
        if (new_fix && sent_err) check("pulses exclusive", 64'(new_fix & sent_err), 64'd0);
        else if (new_fix || sent_err) begin
            if (sb.size() == 0) check("unexpected pulse", {62'd0, new_fix, sent_err}, 64'd0);
            else begin
                ev = sb.pop_front();
                check("pulse is new_fix", 64'(new_fix), 64'(ev.fix));
                check("pulse byte position", 64'(bytes_sent), 64'(ev.byte_no));
                check("pulse time_bcd", 64'(time_bcd), 64'(ev.t));
                check("pulse lat_bcd", 64'(lat_bcd), 64'(ev.la));
                check("pulse lon_bcd", 64'(lon_bcd), 64'(ev.lo));
                check("pulse hemis", {62'd0, lat_south, lon_west}, {62'd0, ev.s, ev.w});
                check("pulse fix_q", 64'(fix_q), 64'(ev.q));
            end
        end
    end

    string t1 = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n";
    string t2 = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48\r\n";
    string t3 = "$GPGGA,123519,4807.038,S,01131.000,W,1,08,0.9,545.4,M,46.9,M,,*48\r\n";
    string t6 = "$GPGGA,123519,4807.038,N,01131.000,E,0,08,0.9,545.4,M,46.9,M,,*46\r\n";
    string rmc = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n";
    string pre = "$GPGGA,123519,48";
    string lng;

    initial begin
        rst = 1'b1; rx_new = 1'b0; rx_data = 8'h00;
        e_t = '0; e_la = '0; e_lo = '0; e_s = 1'b0; e_w = 1'b0; e_q = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("reset");
        check("reset busy", 64'(busy), 64'd0);
        check("reset pulses", {62'd0, new_fix, sent_err}, 64'd0);

        // T1
        e_t = 32'h00123519; e_la = 32'h48070380; e_lo = 32'h01131000; e_q = 4'd1;
        expect_ev(1'b1, bytes_sent + t1.len() - 2);
        send_str(t1);
        check_outs("T1 held");
        // T2: bad checksum, outputs hold
        expect_ev(1'b0, bytes_sent + t2.len() - 2);
        send_str(t2);
        check_outs("T2 held");
        // T3: southern/western hemispheres
        e_s = 1'b1; e_w = 1'b1;
        expect_ev(1'b1, bytes_sent + t3.len() - 2);
        send_str(t3);
        check_outs("T3 held");
        // T4: RMC ignored silently, then T1
        send_str(rmc);
        check("T4 rmc queue", 64'(sb.size()), 64'd0);
        e_s = 1'b0; e_w = 1'b0;
        expect_ev(1'b1, bytes_sent + t1.len() - 2);
        send_str(t1);
        check_outs("T4 held");
        // T5: '$' mid-sentence aborts and restarts
        expect_ev(1'b0, bytes_sent + pre.len() + 1);
        expect_ev(1'b1, bytes_sent + pre.len() + t1.len() - 2);
        for (int i = 0; i < pre.len(); i++) send_byte(pre[i]);
        check("T5 busy mid-sentence", 64'(busy), 64'd1);
        send_str(t1);
        // T5: overlength sentence aborts at byte 83
        lng = "$GPGGA,";
        for (int i = 0; i < 83; i++) lng = {lng, "1"};
        expect_ev(1'b0, bytes_sent + 83);
        send_str(lng);
        check("T5 busy after abort", 64'(busy), 64'd0);
        check_outs("T5 held");
        check("T5 queue drained", 64'(sb.size()), 64'd0);
        // T6: reset mid-sentence, then a no-fix sentence
        for (int i = 0; i < pre.len(); i++) send_byte(pre[i]);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e_t = '0; e_la = '0; e_lo = '0; e_q = '0;
        @(negedge clk);
        check_outs("T6 after reset");
        check("T6 busy after reset", 64'(busy), 64'd0);
        send_str(t6);
        repeat (10) @(negedge clk);
        check_outs("T6 no update");
        check("final queue drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
